// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, control-bundle layout and decode record for the ID/EX stage.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 8;
  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;
  localparam logic [2:0] ALU_OP_SLT = 3'd4;
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_ALU_SRC   = 4;
  localparam int CTRL_REG_DST   = 3;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_op;
  } ctrl_t;
  typedef struct packed {
    logic  valid;
    reg_t  rs;
    reg_t  rt;
    reg_t  rd;
    word_t imm;
    ctrl_t ctrl;
  } dec_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode, register-file, write-back and execute-side signals of the ID/EX stage.
interface id_ex_stage_if;
  import cpu_pkg::*;
  logic  in_valid;
  reg_t  in_rs, in_rt, in_rd;
  word_t in_imm;
  ctrl_t in_ctrl;
  logic  stall, flush;
  reg_t  rf_addr1, rf_addr2;
  word_t rf_data1, rf_data2;
  logic  wb_we;
  reg_t  wb_addr;
  word_t wb_data;
  logic  ex_valid;
  word_t ex_a, ex_b, ex_imm;
  ctrl_t ex_ctrl;
  reg_t  ex_rs, ex_rt, ex_rd;
  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_imm, in_ctrl, stall, flush,
    input  rf_data1, rf_data2, wb_we, wb_addr, wb_data,
    output rf_addr1, rf_addr2,
    output ex_valid, ex_a, ex_b, ex_imm, ex_ctrl, ex_rs, ex_rt, ex_rd
  );
  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_imm, in_ctrl, stall, flush,
    output rf_data1, rf_data2, wb_we, wb_addr, wb_data,
    input  rf_addr1, rf_addr2,
    input  ex_valid, ex_a, ex_b, ex_imm, ex_ctrl, ex_rs, ex_rt, ex_rd
  );
endinterface

// File: rtl/operand_bypass.sv
// operand_bypass: catches a write landing on the same edge a source is read, and forces $0 to zero.
module operand_bypass
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  reg_t  addr,
  input  reg_t  src,
  input  logic  wb_we,
  input  reg_t  wb_addr,
  input  word_t wb_data,
  input  word_t rf_data,
  output word_t op
);
  logic  byp;
  word_t byp_data;
  logic  hit;
  assign hit = wb_we && wb_addr == addr && addr != '0;
  // Unmatched edges clear the flag: the re-read on that edge returns the committed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp      <= 1'b0;
      byp_data <= '0;
    end else begin
      byp <= hit;
      if (hit) byp_data <= wb_data;
    end
  end
  assign op = (src == '0) ? '0 : byp ? byp_data : rf_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: shadow stage s0 waits out the register-file read latency, then
// the ID/EX register captures decode fields with bypass-corrected operands.
module id_ex_stage
  import cpu_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);
  dec_t  s0;
  word_t op1, op2;
  assign bus.rf_addr1 = bus.stall ? s0.rs : bus.in_rs;
  assign bus.rf_addr2 = bus.stall ? s0.rt : bus.in_rt;
  operand_bypass u_byp1 (
    .clk(clk), .rst_n(rst_n), .addr(bus.rf_addr1), .src(s0.rs),
    .wb_we(bus.wb_we), .wb_addr(bus.wb_addr), .wb_data(bus.wb_data),
    .rf_data(bus.rf_data1), .op(op1)
  );
  operand_bypass u_byp2 (
    .clk(clk), .rst_n(rst_n), .addr(bus.rf_addr2), .src(s0.rt),
    .wb_we(bus.wb_we), .wb_addr(bus.wb_addr), .wb_data(bus.wb_data),
    .rf_data(bus.rf_data2), .op(op2)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0;
    end else if (bus.flush) begin
      s0.valid <= 1'b0;
    end else if (!bus.stall) begin
      s0 <= '{valid: bus.in_valid, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
              imm: bus.in_imm, ctrl: bus.in_ctrl};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid <= 1'b0;
      bus.ex_a     <= '0;
      bus.ex_b     <= '0;
      bus.ex_imm   <= '0;
      bus.ex_ctrl  <= '0;
      bus.ex_rs    <= '0;
      bus.ex_rt    <= '0;
      bus.ex_rd    <= '0;
    end else if (bus.flush) begin
      bus.ex_valid <= 1'b0;
    end else if (!bus.stall) begin
      bus.ex_valid <= s0.valid;
      bus.ex_a     <= op1;
      bus.ex_b     <= op2;
      bus.ex_imm   <= s0.imm;
      bus.ex_ctrl  <= s0.ctrl;
      bus.ex_rs    <= s0.rs;
      bus.ex_rt    <= s0.rt;
      bus.ex_rd    <= s0.rd;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: register-file model plus an architectural-state reference for the ID/EX stage.
module tb_id_ex_stage;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] rf [32];
  always @(posedge clk) begin
    bus.rf_data1 <= rf[bus.rf_addr1];
    bus.rf_data2 <= rf[bus.rf_addr2];
    if (bus.wb_we) rf[bus.wb_addr] <= bus.wb_data;
  end
  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [31:0] a, b;
  } mi_t;
  mi_t m_s0, m_ex;
  logic [31:0] arch [32];
  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] imm;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] ea, eb;
  } vec_t;
  vec_t vt [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] rd_arch(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : arch[r];
  endfunction
  task automatic clr();
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = 5'd0;
    bus.wb_data  = 32'd0;
  endtask
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rs ^ rt;
    bus.in_imm   = imm;
    bus.in_ctrl  = ctrl_t'(imm[7:0]);
  endtask
  // Operands reflect every write committed before the edge that moves the instruction into ex.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (bus.flush) begin
        m_s0.v = 1'b0;
        m_ex.v = 1'b0;
      end else if (!bus.stall) begin
        m_ex   = m_s0;
        m_ex.a = rd_arch(m_s0.rs);
        m_ex.b = rd_arch(m_s0.rt);
        m_s0   = '{v: bus.in_valid, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                   imm: bus.in_imm, ctrl: bus.in_ctrl, a: 32'd0, b: 32'd0};
      end
    end
    if (bus.wb_we) arch[bus.wb_addr] = bus.wb_data;
    #1;
    chk("rf_addr1", 32'(bus.rf_addr1), 32'(bus.stall ? m_s0.rs : bus.in_rs));
    chk("rf_addr2", 32'(bus.rf_addr2), 32'(bus.stall ? m_s0.rt : bus.in_rt));
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_ex.v));
    if (m_ex.v) begin
      chk("ex_a", bus.ex_a, m_ex.a);
      chk("ex_b", bus.ex_b, m_ex.b);
      chk("ex_imm", bus.ex_imm, m_ex.imm);
      chk("ex_ctrl", 32'(bus.ex_ctrl), 32'(m_ex.ctrl));
      chk("ex_rs", 32'(bus.ex_rs), 32'(m_ex.rs));
      chk("ex_rt", 32'(bus.ex_rt), 32'(m_ex.rt));
      chk("ex_rd", 32'(bus.ex_rd), 32'(m_ex.rd));
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ex_a", bus.ex_a, 32'd0);
    chk("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
    m_s0 = '{default: '0};
    m_ex = '{default: '0};
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    vt[0] = '{5'd3, 5'd4, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'h0,    32'h11,   32'h22};
    vt[1] = '{5'd5, 5'd4, 32'h0000_0010, 1'b1, 5'd5, 32'hDEAD, 32'hDEAD, 32'h22};
    vt[2] = '{5'd0, 5'd5, 32'h0000_0020, 1'b1, 5'd0, 32'h1234, 32'h0,    32'hDEAD};
    vt[3] = '{5'd6, 5'd6, 32'h0000_0030, 1'b1, 5'd6, 32'hCAFE, 32'hCAFE, 32'hCAFE};
    vt[4] = '{5'd0, 5'd0, 32'h0000_0040, 1'b0, 5'd0, 32'h0,    32'h0,    32'h0};
    vt[5] = '{5'd7, 5'd3, 32'h0000_0050, 1'b1, 5'd3, 32'h5555, 32'h107,  32'h5555};
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    m_s0 = '{default: '0};
    m_ex = '{default: '0};
    clr();
    issue(5'd0, 5'd0, 32'd0);
    bus.in_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wb_we   = 1'b1;
      bus.wb_addr = 5'(i);
      bus.wb_data = (i == 3) ? 32'h11 : (i == 4) ? 32'h22 : 32'h100 + 32'(i);
      step();
    end
    clr();
    step();
    for (int i = 0; i < 6; i++) begin
      clr();
      issue(vt[i].rs, vt[i].rt, vt[i].imm);
      bus.wb_we   = vt[i].we;
      bus.wb_addr = vt[i].wa;
      bus.wb_data = vt[i].wd;
      step();
      clr();
      step();
      chk($sformatf("vec%0d_valid", i), 32'(bus.ex_valid), 32'd1);
      chk($sformatf("vec%0d_a", i), bus.ex_a, vt[i].ea);
      chk($sformatf("vec%0d_b", i), bus.ex_b, vt[i].eb);
      chk($sformatf("vec%0d_imm", i), bus.ex_imm, vt[i].imm);
    end
    // Stall spanning a write to the held source.
    clr();
    issue(5'd1, 5'd2, 32'h60);
    step();
    issue(5'd3, 5'd7, 32'h70);
    step();
    clr();
    for (int i = 0; i < 3; i++) begin
      bus.stall   = 1'b1;
      bus.wb_we   = (i == 1);
      bus.wb_addr = 5'd7;
      bus.wb_data = 32'hBEEF;
      step();
      chk("stall_hold_valid", 32'(bus.ex_valid), 32'd1);
      chk("stall_hold_a", bus.ex_a, 32'h101);
      chk("stall_hold_b", bus.ex_b, 32'h102);
    end
    clr();
    step();
    chk("stall_rel_a", bus.ex_a, 32'h5555);
    chk("stall_rel_b", bus.ex_b, 32'hBEEF);
    chk("stall_rel_imm", bus.ex_imm, 32'h70);
    // Flush wins over stall and kills both s0 and ex.
    issue(5'd1, 5'd2, 32'h80);
    step();
    issue(5'd2, 5'd1, 32'h90);
    step();
    clr();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    chk("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
    clr();
    step();
    chk("flush_s0_killed", 32'(bus.ex_valid), 32'd0);
    // Asynchronous reset during back-to-back issue.
    issue(5'd4, 5'd5, 32'hA0);
    step();
    issue(5'd5, 5'd4, 32'hB0);
    step();
    do_reset();
    clr();
    issue(5'd7, 5'd4, 32'hC0);
    step();
    chk("post_rst_first", 32'(bus.ex_valid), 32'd0);
    clr();
    step();
    chk("post_rst_valid", 32'(bus.ex_valid), 32'd1);
    chk("post_rst_a", bus.ex_a, 32'hBEEF);
    chk("post_rst_b", bus.ex_b, 32'h22);
    for (int c = 0; c < 600; c++) begin
      clr();
      if ($urandom_range(0, 3) != 0) issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
      bus.stall   = ($urandom_range(0, 3) == 0);
      bus.flush   = ($urandom_range(0, 11) == 0);
      bus.wb_we   = $urandom_range(0, 1) == 1;
      bus.wb_addr = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      if (c == 300) do_reset();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
